// File: rtl/comparador_serial_pkg.sv
// Shared definitions for the serial magnitude comparator: state codes,
// state width and a helper for sizing the slice counter.
package comparador_serial_pkg;

  // Width of the FSM state code as seen on db_estado.
  localparam int ESTADO_W = 2;

  // State codes are fixed so that db_estado reads INICIAL=0, COMPARA=1, FIM=2.
  typedef enum logic [ESTADO_W-1:0] {
    INICIAL = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  // Counter width for n slices. A single slice still needs a 1-bit
  // counter, because a zero-width vector is not legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comparador_fatia.sv
// Combinational comparison of one SLICE-bit slice. The slice is treated as
// unsigned. When inverte_msb is set, the MSB of both operands is flipped
// first, so the top slice of a two's-complement number orders correctly.
module comparador_fatia #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             inverte_msb,
  output logic             lt,
  output logic             gt
);

  logic [SLICE-1:0] a_m;
  logic [SLICE-1:0] b_m;

  // Bias the sign bit (top slice only) and then compare magnitudes.
  always_comb begin
    a_m            = a;
    b_m            = b;
    a_m[SLICE-1]   = a[SLICE-1] ^ inverte_msb;
    b_m[SLICE-1]   = b[SLICE-1] ^ inverte_msb;
    lt             = (a_m < b_m);
    gt             = (a_m > b_m);
  end

endmodule

// File: rtl/comparador_serial.sv
// Serial magnitude comparator. It walks the captured operands SLICE bits at
// a time, MSB slice first, and stops at the first slice that differs. When
// every slice is equal, the 7485-style cascade inputs supply the result.
//
// Handshake: iniciar is a start request. It is sampled only in INICIAL, and
// once it is accepted, A/B/modo/cascade are captured on that same edge.
// iniciar is ignored (not queued) while ocupado=1. Completion is signalled by
// pronto, a single-cycle pulse in FIM. ALBo/AGBo/AEBo are valid from that
// cycle and hold until the next completion.
module comparador_serial
  import comparador_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             modo,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ALBi,
  input  logic             AGBi,
  input  logic             AEBi,
  output logic             ALBo,
  output logic             AGBo,
  output logic             AEBo,
  output logic             pronto,
  output logic             ocupado,
  output logic [1:0]       db_estado
);

  localparam int                NSLICES = WIDTH / SLICE;
  localparam int                IDX_W   = idx_width(NSLICES);
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(NSLICES - 1);

  // Reject widths that do not split into whole slices.
  generate
    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_param_check
      $error("comparador_serial: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  estado_t          estado;
  estado_t          estado_nxt;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             modo_q;
  logic             albi_q;
  logic             agbi_q;
  logic             aebi_q;

  logic             alb_q;
  logic             agb_q;
  logic             aeb_q;

  logic [SLICE-1:0] fatia_a;
  logic [SLICE-1:0] fatia_b;
  logic             inverte;
  logic             fatia_lt;
  logic             fatia_gt;
  logic             fatia_dif;
  logic             ultima;

  // Select the slice under examination and decide whether the sign bit applies.
  always_comb begin
    fatia_a   = a_q[int'(idx) * SLICE +: SLICE];
    fatia_b   = b_q[int'(idx) * SLICE +: SLICE];
    inverte   = modo_q && (idx == IDX_TOP);
    ultima    = (idx == '0);
  end

  comparador_fatia #(
    .SLICE (SLICE)
  ) u_fatia (
    .a           (fatia_a),
    .b           (fatia_b),
    .inverte_msb (inverte),
    .lt          (fatia_lt),
    .gt          (fatia_gt)
  );

  assign fatia_dif = fatia_lt | fatia_gt;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= estado_nxt;
    end
  end

  // Next-state logic: a run ends on the first differing slice or after slice 0.
  always_comb begin
    estado_nxt = estado;
    case (estado)
      INICIAL: begin
        if (iniciar) begin
          estado_nxt = COMPARA;
        end
      end
      COMPARA: begin
        if (fatia_dif || ultima) begin
          estado_nxt = FIM;
        end
      end
      FIM: begin
        estado_nxt = INICIAL;
      end
      default: begin
        estado_nxt = INICIAL;
      end
    endcase
  end

  // Operand capture, slice counter and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx    <= IDX_TOP;
      a_q    <= '0;
      b_q    <= '0;
      modo_q <= 1'b0;
      albi_q <= 1'b0;
      agbi_q <= 1'b0;
      aebi_q <= 1'b0;
      alb_q  <= 1'b0;
      agb_q  <= 1'b0;
      aeb_q  <= 1'b0;
    end else begin
      case (estado)
        INICIAL: begin
          if (iniciar) begin
            idx    <= IDX_TOP;
            a_q    <= A;
            b_q    <= B;
            modo_q <= modo;
            albi_q <= ALBi;
            agbi_q <= AGBi;
            aebi_q <= AEBi;
          end
        end
        COMPARA: begin
          if (fatia_dif) begin
            alb_q <= fatia_lt;
            agb_q <= fatia_gt;
            aeb_q <= 1'b0;
          end else if (ultima) begin
            // All slices equal: the cascade inputs pass through unchanged,
            // illegal combinations included.
            alb_q <= albi_q;
            agb_q <= agbi_q;
            aeb_q <= aebi_q;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    pronto    = (estado == FIM);
    ocupado   = (estado == COMPARA) || (estado == FIM);
    db_estado = estado;
  end

  assign ALBo = alb_q;
  assign AGBo = agb_q;
  assign AEBo = aeb_q;

endmodule
